// File: rtl/rs_syndrome.sv
// Streaming Reed-Solomon syndrome generator over GF(2^8) (poly 0x11D, alpha = 0x02).
// Accumulates S_j = r(alpha^j), j = 0..2T-1, in Horner form at one symbol per cycle.
module rs_syndrome #(
    parameter int N = 255,
    parameter int T = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    input  logic            in_last,
    output logic            synd_valid,
    input  logic            synd_ready,
    output logic [16*T-1:0] synd,
    output logic            err_flag,
    output logic            len_err
);
    localparam int         NS    = 2 * T;
    localparam logic [7:0] N_CNT = 8'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic logic [7:0] gf_mul_alpha(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    // pw is an elaboration-time constant at every call site, so this unrolls to a pure XOR network
    function automatic logic [7:0] gf_mul_alpha_pow(input logic [7:0] x, input int pw);
        logic [7:0] acc;
        acc = x;
        for (int k = 0; k < NS; k++) begin
            if (k < pw) begin
                acc = gf_mul_alpha(acc);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_e             state_q;
    state_e             state_d;
    logic               rst_sync_q;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;
    logic [NS-1:0][7:0] synd_q;
    logic [NS-1:0][7:0] synd_d;
    logic               err_q;
    logic               err_d;
    logic               len_q;
    logic               len_d;

    logic [NS-1:0][7:0] horner_s;
    logic [7:0]         cnt_next_s;
    logic               accept_s;
    logic               handshake_s;
    logic               at_n_s;
    logic               frame_end_s;

    // Reset-release synchronizer: acceptance is gated until the first clk edge after reset_n rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    assign in_ready    = rst_sync_q & (state_q != ST_HOLD);
    assign synd_valid  = (state_q == ST_HOLD);
    assign accept_s    = in_valid & in_ready;
    assign handshake_s = synd_valid & synd_ready;
    assign cnt_next_s  = (state_q == ST_IDLE) ? 8'd1 : (cnt_q + 8'd1);
    assign at_n_s      = (cnt_next_s == N_CNT);
    assign frame_end_s = accept_s & (in_last | at_n_s);

    for (genvar j = 0; j < NS; j++) begin : g_horner
        assign horner_s[j] = gf_mul_alpha_pow(synd_q[j], j) ^ in_data;
    end

    // Next-state logic; a framing error is exactly one of (in_last, count hit N) on the final symbol
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        synd_d  = synd_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept_s) begin
                    cnt_d   = cnt_next_s;
                    synd_d  = (state_q == ST_IDLE) ? {NS{in_data}} : horner_s;
                    len_d   = frame_end_s ? (in_last ^ at_n_s) : 1'b0;
                    state_d = frame_end_s ? ST_HOLD : ST_ACCUM;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (handshake_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_d = |synd_d;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            synd_q  <= '0;
            err_q   <= 1'b0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            synd_q  <= synd_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    assign synd     = synd_q;
    assign err_flag = err_q;
    assign len_err  = len_q;

endmodule
